// File: rtl/core_mem_arbiter_pkg.sv
// rtl/core_mem_arbiter_pkg.sv - shared encodings for the IF/MEM to AXI4-Lite arbiter
package core_mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_ADDR = 3'd3,
    ST_WR_RESP = 3'd4
  } arb_state_t;

  localparam logic [1:0] AXI_RESP_OKAY = 2'b00;
  localparam logic [2:0] AXI_PROT_INSN = 3'b100;
  localparam logic [2:0] AXI_PROT_DATA = 3'b000;

  // Requester index inside the 2-bit request/grant vectors
  localparam int GNT_IMEM = 0;
  localparam int GNT_DMEM = 1;

endpackage

// File: rtl/core_arb_rr2.sv
// rtl/core_arb_rr2.sv - combinational two-way round-robin picker
// last_grant is the index of the previous winner; on a tie the other side wins.
module core_arb_rr2 (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic [1:0] grant
);

  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant = last_grant ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/core_mem_arbiter.sv
// rtl/core_mem_arbiter.sv - shares one AXI4-Lite master between fetch and load/store
// One transaction at a time; each requester gets a registered one-cycle DONE pulse.
module core_mem_arbiter
  import core_mem_arbiter_pkg::*;
(
  input  logic        CLK,
  input  logic        NRST,

  input  logic        IMEM_REQ,
  input  logic [31:0] IMEM_ADDR,
  output logic [31:0] IMEM_RDATA,
  output logic        IMEM_DONE,
  output logic        IMEM_ERR,

  input  logic        DMEM_REQ,
  input  logic        DMEM_WE,
  input  logic [31:0] DMEM_ADDR,
  input  logic [31:0] DMEM_WDATA,
  input  logic [3:0]  DMEM_STRB,
  output logic [31:0] DMEM_RDATA,
  output logic        DMEM_DONE,
  output logic        DMEM_ERR,

  output logic [31:0] M_AXI_ARADDR,
  output logic [2:0]  M_AXI_ARPROT,
  output logic        M_AXI_ARVALID,
  input  logic        M_AXI_ARREADY,
  input  logic [31:0] M_AXI_RDATA,
  input  logic [1:0]  M_AXI_RRESP,
  input  logic        M_AXI_RVALID,
  output logic        M_AXI_RREADY,
  output logic [31:0] M_AXI_AWADDR,
  output logic        M_AXI_AWVALID,
  input  logic        M_AXI_AWREADY,
  output logic [31:0] M_AXI_WDATA,
  output logic [3:0]  M_AXI_WSTRB,
  output logic        M_AXI_WVALID,
  input  logic        M_AXI_WREADY,
  input  logic [1:0]  M_AXI_BRESP,
  input  logic        M_AXI_BVALID,
  output logic        M_AXI_BREADY
);

  arb_state_t  state;
  logic        last_grant;
  logic [1:0]  req;
  logic [1:0]  grant;
  logic [31:0] pay_addr;
  logic [31:0] pay_wdata;
  logic [3:0]  pay_strb;
  logic        pay_imem;
  logic        aw_done;
  logic        w_done;
  logic        aw_hs;
  logic        w_hs;
  logic        aw_done_nx;
  logic        w_done_nx;

  // A requester is masked during its own DONE cycle so the held REQ is not regranted.
  assign req[GNT_IMEM] = IMEM_REQ & ~IMEM_DONE;
  assign req[GNT_DMEM] = DMEM_REQ & ~DMEM_DONE;

  core_arb_rr2 u_rr2 (
    .req        (req),
    .last_grant (last_grant),
    .grant      (grant)
  );

  // Payload registers only change in IDLE, so everything stays stable while VALID is up.
  assign M_AXI_ARADDR = pay_addr;
  assign M_AXI_AWADDR = pay_addr;
  assign M_AXI_WDATA  = pay_wdata;
  assign M_AXI_WSTRB  = pay_strb;
  assign M_AXI_ARPROT = pay_imem ? AXI_PROT_INSN : AXI_PROT_DATA;

  assign aw_hs      = M_AXI_AWVALID & M_AXI_AWREADY;
  assign w_hs       = M_AXI_WVALID & M_AXI_WREADY;
  assign aw_done_nx = aw_done | aw_hs;
  assign w_done_nx  = w_done | w_hs;

  always_ff @(posedge CLK or negedge NRST) begin
    if (!NRST) begin
      state         <= ST_IDLE;
      last_grant    <= 1'b0;
      pay_addr      <= '0;
      pay_wdata     <= '0;
      pay_strb      <= '0;
      pay_imem      <= 1'b0;
      aw_done       <= 1'b0;
      w_done        <= 1'b0;
      M_AXI_ARVALID <= 1'b0;
      M_AXI_RREADY  <= 1'b0;
      M_AXI_AWVALID <= 1'b0;
      M_AXI_WVALID  <= 1'b0;
      M_AXI_BREADY  <= 1'b0;
      IMEM_RDATA    <= '0;
      IMEM_DONE     <= 1'b0;
      IMEM_ERR      <= 1'b0;
      DMEM_RDATA    <= '0;
      DMEM_DONE     <= 1'b0;
      DMEM_ERR      <= 1'b0;
    end else begin
      IMEM_DONE <= 1'b0;
      DMEM_DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (|grant) begin
            pay_imem   <= grant[GNT_IMEM];
            pay_addr   <= grant[GNT_IMEM] ? IMEM_ADDR : DMEM_ADDR;
            pay_wdata  <= DMEM_WDATA;
            pay_strb   <= DMEM_STRB;
            last_grant <= grant[GNT_DMEM];
            if (grant[GNT_DMEM] && DMEM_WE) begin
              M_AXI_AWVALID <= 1'b1;
              M_AXI_WVALID  <= 1'b1;
              aw_done       <= 1'b0;
              w_done        <= 1'b0;
              state         <= ST_WR_ADDR;
            end else begin
              M_AXI_ARVALID <= 1'b1;
              state         <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          if (M_AXI_ARREADY) begin
            M_AXI_ARVALID <= 1'b0;
            M_AXI_RREADY  <= 1'b1;
            state         <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (M_AXI_RVALID) begin
            M_AXI_RREADY <= 1'b0;
            state        <= ST_IDLE;
            if (pay_imem) begin
              IMEM_RDATA <= M_AXI_RDATA;
              IMEM_ERR   <= (M_AXI_RRESP != AXI_RESP_OKAY);
              IMEM_DONE  <= 1'b1;
            end else begin
              DMEM_RDATA <= M_AXI_RDATA;
              DMEM_ERR   <= (M_AXI_RRESP != AXI_RESP_OKAY);
              DMEM_DONE  <= 1'b1;
            end
          end
        end
        ST_WR_ADDR: begin
          // AW and W channels retire independently; both may complete in one cycle.
          if (aw_hs) M_AXI_AWVALID <= 1'b0;
          if (w_hs)  M_AXI_WVALID  <= 1'b0;
          aw_done <= aw_done_nx;
          w_done  <= w_done_nx;
          if (aw_done_nx && w_done_nx) begin
            M_AXI_BREADY <= 1'b1;
            state        <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            M_AXI_BREADY <= 1'b0;
            DMEM_ERR     <= (M_AXI_BRESP != AXI_RESP_OKAY);
            DMEM_DONE    <= 1'b1;
            state        <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_core_mem_arbiter.sv
// tb/tb_core_mem_arbiter.sv - scoreboard bench for core_mem_arbiter
module tb_core_mem_arbiter;

  logic        CLK;
  logic        NRST;
  logic        IMEM_REQ;
  logic [31:0] IMEM_ADDR;
  logic [31:0] IMEM_RDATA;
  logic        IMEM_DONE;
  logic        IMEM_ERR;
  logic        DMEM_REQ;
  logic        DMEM_WE;
  logic [31:0] DMEM_ADDR;
  logic [31:0] DMEM_WDATA;
  logic [3:0]  DMEM_STRB;
  logic [31:0] DMEM_RDATA;
  logic        DMEM_DONE;
  logic        DMEM_ERR;
  logic [31:0] M_AXI_ARADDR;
  logic [2:0]  M_AXI_ARPROT;
  logic        M_AXI_ARVALID;
  logic        M_AXI_ARREADY;
  logic [31:0] M_AXI_RDATA;
  logic [1:0]  M_AXI_RRESP;
  logic        M_AXI_RVALID;
  logic        M_AXI_RREADY;
  logic [31:0] M_AXI_AWADDR;
  logic        M_AXI_AWVALID;
  logic        M_AXI_AWREADY;
  logic [31:0] M_AXI_WDATA;
  logic [3:0]  M_AXI_WSTRB;
  logic        M_AXI_WVALID;
  logic        M_AXI_WREADY;
  logic [1:0]  M_AXI_BRESP;
  logic        M_AXI_BVALID;
  logic        M_AXI_BREADY;

  core_mem_arbiter dut (
    .CLK(CLK), .NRST(NRST),
    .IMEM_REQ(IMEM_REQ), .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA),
    .IMEM_DONE(IMEM_DONE), .IMEM_ERR(IMEM_ERR),
    .DMEM_REQ(DMEM_REQ), .DMEM_WE(DMEM_WE), .DMEM_ADDR(DMEM_ADDR),
    .DMEM_WDATA(DMEM_WDATA), .DMEM_STRB(DMEM_STRB), .DMEM_RDATA(DMEM_RDATA),
    .DMEM_DONE(DMEM_DONE), .DMEM_ERR(DMEM_ERR),
    .M_AXI_ARADDR(M_AXI_ARADDR), .M_AXI_ARPROT(M_AXI_ARPROT),
    .M_AXI_ARVALID(M_AXI_ARVALID), .M_AXI_ARREADY(M_AXI_ARREADY),
    .M_AXI_RDATA(M_AXI_RDATA), .M_AXI_RRESP(M_AXI_RRESP),
    .M_AXI_RVALID(M_AXI_RVALID), .M_AXI_RREADY(M_AXI_RREADY),
    .M_AXI_AWADDR(M_AXI_AWADDR), .M_AXI_AWVALID(M_AXI_AWVALID),
    .M_AXI_AWREADY(M_AXI_AWREADY), .M_AXI_WDATA(M_AXI_WDATA),
    .M_AXI_WSTRB(M_AXI_WSTRB), .M_AXI_WVALID(M_AXI_WVALID),
    .M_AXI_WREADY(M_AXI_WREADY), .M_AXI_BRESP(M_AXI_BRESP),
    .M_AXI_BVALID(M_AXI_BVALID), .M_AXI_BREADY(M_AXI_BREADY)
  );

  localparam logic [31:0] RD_KEY = 32'hCAFE0000;

  typedef struct {
    bit          who;
    logic [31:0] rdata;
    bit          err;
    bit          chk;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  // Slave configuration and state
  int          ar_wait, r_wait, aw_wait, w_wait, b_wait;
  bit          fix_en;
  logic [31:0] fix_data;
  logic [1:0]  rresp_v, bresp_v;
  bit          ar_f, r_f, aw_f, w_f, b_f, rd_pend, wr_pend, aw_got, w_got;
  int          ar_c, r_c, aw_c, w_c, b_c;
  logic [31:0] lat_addr;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic pop_cmp(input bit who, input logic [31:0] d, input logic e);
    exp_t x;
    if (sb.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL sb_unexpected_done: got DONE from requester %0d expected none", who);
    end else begin
      x = sb.pop_front();
      check("sb_requester", {31'b0, who}, {31'b0, x.who});
      if (x.chk) check("sb_rdata", d, x.rdata);
      check("sb_err", {31'b0, e}, {31'b0, x.err});
    end
  endtask

  // Monitor: pops the scoreboard on every DONE pulse
  initial begin
    forever begin
      @(negedge CLK);
      if (NRST) begin
        if (IMEM_DONE) pop_cmp(1'b0, IMEM_RDATA, IMEM_ERR);
        if (DMEM_DONE) pop_cmp(1'b1, DMEM_RDATA, DMEM_ERR);
      end
    end
  end

  // AXI4-Lite slave: decides its inputs at each falling edge from DUT outputs
  initial begin
    forever begin
      @(negedge CLK);
      if (!NRST) begin
        ar_f = 0; r_f = 0; aw_f = 0; w_f = 0; b_f = 0;
        rd_pend = 0; wr_pend = 0; aw_got = 0; w_got = 0;
        ar_c = 0; r_c = 0; aw_c = 0; w_c = 0; b_c = 0;
        lat_addr = '0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = '0; M_AXI_RRESP = '0;
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = '0;
        continue;
      end
      if (ar_f) begin rd_pend = 1; r_c = 0; end
      if (r_f) rd_pend = 0;
      if (aw_f) aw_got = 1;
      if (w_f) w_got = 1;
      if (b_f) wr_pend = 0;
      if (aw_got && w_got) begin wr_pend = 1; b_c = 0; aw_got = 0; w_got = 0; end
      if (M_AXI_ARVALID) begin M_AXI_ARREADY = (ar_c >= ar_wait); ar_c++; end
      else begin M_AXI_ARREADY = 0; ar_c = 0; end
      if (M_AXI_AWVALID) begin M_AXI_AWREADY = (aw_c >= aw_wait); aw_c++; end
      else begin M_AXI_AWREADY = 0; aw_c = 0; end
      if (M_AXI_WVALID) begin M_AXI_WREADY = (w_c >= w_wait); w_c++; end
      else begin M_AXI_WREADY = 0; w_c = 0; end
      M_AXI_RVALID = rd_pend && (r_c >= r_wait);
      if (rd_pend) r_c++;
      M_AXI_RDATA = M_AXI_RVALID ? (fix_en ? fix_data : (lat_addr ^ RD_KEY)) : 32'h0;
      M_AXI_RRESP = M_AXI_RVALID ? rresp_v : 2'b00;
      M_AXI_BVALID = wr_pend && (b_c >= b_wait);
      if (wr_pend) b_c++;
      M_AXI_BRESP = M_AXI_BVALID ? bresp_v : 2'b00;
      ar_f = M_AXI_ARVALID && M_AXI_ARREADY;
      if (ar_f) lat_addr = M_AXI_ARADDR;
      r_f  = M_AXI_RVALID && M_AXI_RREADY;
      aw_f = M_AXI_AWVALID && M_AXI_AWREADY;
      w_f  = M_AXI_WVALID && M_AXI_WREADY;
      b_f  = M_AXI_BVALID && M_AXI_BREADY;
    end
  end

  // Counts DONE pulses from the current cycle (cycle 0) onward, bounded by budget.
  task automatic wait_dones(input int n, input int budget, output int first, output int last);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    first = -1;
    last = -1;
    while (got < n && cyc < budget) begin
      @(negedge CLK);
      cyc++;
      if (IMEM_DONE || DMEM_DONE) begin
        got++;
        if (got == 1) first = cyc;
        last = cyc;
      end
    end
    check("done_count", got, n);
  endtask

  initial begin
    int f, l;
    NRST = 0; IMEM_REQ = 0; IMEM_ADDR = '0; DMEM_REQ = 0; DMEM_WE = 0;
    DMEM_ADDR = '0; DMEM_WDATA = '0; DMEM_STRB = '0;
    ar_wait = 0; r_wait = 0; aw_wait = 0; w_wait = 0; b_wait = 0;
    fix_en = 0; fix_data = '0; rresp_v = 2'b00; bresp_v = 2'b00;
    repeat (3) @(negedge CLK);

    check("rst_arvalid", M_AXI_ARVALID, 0);
    check("rst_awvalid", M_AXI_AWVALID, 0);
    check("rst_wvalid",  M_AXI_WVALID, 0);
    check("rst_rready",  M_AXI_RREADY, 0);
    check("rst_bready",  M_AXI_BREADY, 0);
    check("rst_dones",   {IMEM_DONE, DMEM_DONE, IMEM_ERR, DMEM_ERR}, 0);
    check("rst_imem_rdata", IMEM_RDATA, 0);
    check("rst_dmem_rdata", DMEM_RDATA, 0);
    check("rst_araddr", M_AXI_ARADDR, 0);
    check("rst_wdata_strb", M_AXI_WDATA | {28'b0, M_AXI_WSTRB}, 0);
    NRST = 1;
    @(negedge CLK);

    // Tie out of reset: DMEM first, then strict alternation with no lost cycle
    IMEM_ADDR = 32'h400; DMEM_ADDR = 32'h800; DMEM_WE = 0;
    IMEM_REQ = 1; DMEM_REQ = 1;
    sb.push_back('{1'b1, 32'h800 ^ RD_KEY, 1'b0, 1'b1});
    sb.push_back('{1'b0, 32'h400 ^ RD_KEY, 1'b0, 1'b1});
    sb.push_back('{1'b1, 32'h800 ^ RD_KEY, 1'b0, 1'b1});
    sb.push_back('{1'b0, 32'h400 ^ RD_KEY, 1'b0, 1'b1});
    wait_dones(4, 60, f, l);
    IMEM_REQ = 0; DMEM_REQ = 0;
    check("tie_first_done_cycle", f, 3);
    check("tie_done_spacing", l - f, 9);
    repeat (2) @(negedge CLK);

    // Single IMEM read, zero-wait slave
    fix_en = 1; fix_data = 32'h00000013; rresp_v = 2'b00;
    IMEM_REQ = 1; IMEM_ADDR = 32'h100;
    sb.push_back('{1'b0, 32'h00000013, 1'b0, 1'b1});
    @(negedge CLK);
    check("rd1_arvalid", M_AXI_ARVALID, 1);
    check("rd1_arprot", M_AXI_ARPROT, 3'b100);
    check("rd1_araddr", M_AXI_ARADDR, 32'h100);
    @(negedge CLK);
    check("rd1_rready", M_AXI_RREADY, 1);
    check("rd1_arvalid_low", M_AXI_ARVALID, 0);
    @(negedge CLK);
    check("rd1_done_cycle3", IMEM_DONE, 1);
    IMEM_REQ = 0;
    @(negedge CLK);
    check("rd1_done_pulse", IMEM_DONE, 0);
    @(negedge CLK);

    // DMEM store, AW accepted at cycle 1, W at cycle 3
    aw_wait = 0; w_wait = 2; b_wait = 0; bresp_v = 2'b00;
    DMEM_REQ = 1; DMEM_WE = 1; DMEM_ADDR = 32'h2000;
    DMEM_WDATA = 32'hDEADBEEF; DMEM_STRB = 4'b0011;
    sb.push_back('{1'b1, 32'h0, 1'b0, 1'b0});
    @(negedge CLK);
    check("wr_c1_valids", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_ARVALID}, 3'b110);
    check("wr_awaddr", M_AXI_AWADDR, 32'h2000);
    check("wr_wdata", M_AXI_WDATA, 32'hDEADBEEF);
    check("wr_wstrb", M_AXI_WSTRB, 4'b0011);
    @(negedge CLK);
    check("wr_c2_valids", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b01);
    @(negedge CLK);
    check("wr_c3_w_b", {M_AXI_WVALID, M_AXI_BREADY}, 2'b10);
    @(negedge CLK);
    check("wr_c4_w_b", {M_AXI_WVALID, M_AXI_BREADY}, 2'b01);
    @(negedge CLK);
    check("wr_c5_done", {DMEM_DONE, M_AXI_BREADY}, 2'b10);
    DMEM_REQ = 0; DMEM_WE = 0; w_wait = 0;
    @(negedge CLK);

    // DMEM load with SLVERR, then a clean IMEM read
    fix_data = 32'h12345678; rresp_v = 2'b10;
    DMEM_REQ = 1; DMEM_ADDR = 32'h3000;
    sb.push_back('{1'b1, 32'h12345678, 1'b1, 1'b1});
    @(negedge CLK);
    check("ld_arprot", M_AXI_ARPROT, 3'b000);
    wait_dones(1, 30, f, l);
    DMEM_REQ = 0;
    check("ld_done_cycle", f + 1, 3);
    rresp_v = 2'b00; fix_data = 32'h55AA55AA;
    IMEM_REQ = 1; IMEM_ADDR = 32'h104;
    sb.push_back('{1'b0, 32'h55AA55AA, 1'b0, 1'b1});
    wait_dones(1, 30, f, l);
    IMEM_REQ = 0;
    check("rd2_done_cycle", f, 3);
    @(negedge CLK);

    // ARREADY stalls 5 cycles while IMEM_ADDR wanders
    fix_en = 0; ar_wait = 5;
    IMEM_REQ = 1; IMEM_ADDR = 32'h300;
    sb.push_back('{1'b0, 32'h300 ^ RD_KEY, 1'b0, 1'b1});
    for (int c = 1; c <= 6; c++) begin
      @(negedge CLK);
      check("stall_arvalid", M_AXI_ARVALID, 1);
      check("stall_araddr", M_AXI_ARADDR, 32'h300);
      IMEM_ADDR = 32'h300 + 32'(c * 4);
    end
    @(negedge CLK);
    check("stall_c7", {M_AXI_ARVALID, M_AXI_RREADY}, 2'b01);
    @(negedge CLK);
    check("stall_done_c8", IMEM_DONE, 1);
    IMEM_REQ = 0; ar_wait = 0;
    @(negedge CLK);

    // Reset while RD_DATA has RVALID pending; that DONE is lost
    r_wait = 1;
    DMEM_REQ = 1; DMEM_ADDR = 32'h900;
    repeat (3) @(negedge CLK);
    #2;
    NRST = 0;
    #1;
    check("mrst_arvalid_rready", {M_AXI_ARVALID, M_AXI_RREADY}, 2'b00);
    check("mrst_dones", {IMEM_DONE, DMEM_DONE, IMEM_ERR, DMEM_ERR}, 0);
    check("mrst_dmem_rdata", DMEM_RDATA, 0);
    check("mrst_imem_rdata", IMEM_RDATA, 0);
    DMEM_REQ = 0;
    r_wait = 0;
    repeat (2) @(negedge CLK);
    NRST = 1;
    @(negedge CLK);
    IMEM_ADDR = 32'h500; DMEM_ADDR = 32'hA00;
    IMEM_REQ = 1; DMEM_REQ = 1;
    sb.push_back('{1'b1, 32'hA00 ^ RD_KEY, 1'b0, 1'b1});
    sb.push_back('{1'b0, 32'h500 ^ RD_KEY, 1'b0, 1'b1});
    @(negedge CLK);
    check("prst_tie_araddr", M_AXI_ARADDR, 32'hA00);
    check("prst_tie_arprot", M_AXI_ARPROT, 3'b000);
    wait_dones(2, 40, f, l);
    IMEM_REQ = 0; DMEM_REQ = 0;
    repeat (3) @(negedge CLK);

    check("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/core_mem_arbiter.md
# core_mem_arbiter

Shares one AXI4-Lite master port between the pipeline's instruction-fetch requester and data-memory (load/store) requester. It runs one transaction at a time. Two-way round-robin arbitration runs from an IDLE state, and each requester gets a one-cycle registered DONE pulse with read data and error status. It sits between the core's IF/MEM stages and the system bus, and supplies the completion events that drive the hazard/stall logic.

## Interface
- No parameters; address/data fixed at 32 bits, strobe 4 bits.
- CLK  in  1  system clock, all logic on rising edge
- NRST  in  1  reset, asynchronous, active-low
- IMEM_REQ  in  1  fetch request; held until IMEM_DONE
- IMEM_ADDR  in  32  fetch address, stable while IMEM_REQ
- IMEM_RDATA  out  32  fetched word, valid with IMEM_DONE
- IMEM_DONE  out  1  one-cycle completion pulse
- IMEM_ERR  out  1  RRESP≠OKAY, valid with IMEM_DONE
- DMEM_REQ  in  1  load/store request; held until DMEM_DONE
- DMEM_WE  in  1  1 = store, 0 = load
- DMEM_ADDR  in  32  data address
- DMEM_WDATA  in  32  store data
- DMEM_STRB  in  4  store byte strobes
- DMEM_RDATA  out  32  load word, valid with DMEM_DONE
- DMEM_DONE  out  1  one-cycle completion pulse
- DMEM_ERR  out  1  RRESP/BRESP≠OKAY, valid with DMEM_DONE
- M_AXI_ARADDR/ARPROT/ARVALID out 32/3/1, M_AXI_ARREADY in 1
- M_AXI_RDATA/RRESP/RVALID in 32/2/1, M_AXI_RREADY out 1
- M_AXI_AWADDR/AWVALID out 32/1, M_AXI_AWREADY in 1
- M_AXI_WDATA/WSTRB/WVALID out 32/4/1, M_AXI_WREADY in 1
- M_AXI_BRESP/BVALID in 2/1, M_AXI_BREADY out 1

## Operation
- FSM states: IDLE, RD_ADDR, RD_DATA, WR_ADDR, WR_RESP.
- IDLE, grant selection:
  - A requester is eligible when its REQ is high and its DONE is low. The DONE-cycle mask stops a same-cycle regrant.
  - If only one is eligible, grant it.
  - If both are eligible, grant the one that is not `last_grant`.
  - On grant: latch address, WE, WDATA and STRB into payload registers; update `last_grant`.
- IMEM grant or DMEM load → RD_ADDR. DMEM store → WR_ADDR.
- RD_ADDR: ARVALID=1. ARPROT=3'b100 for IMEM and 3'b000 for DMEM. Go to RD_DATA on ARVALID&ARREADY.
- RD_DATA: RREADY=1. On RVALID: register RDATA into the granted requester's RDATA output, set ERR=(RRESP≠2'b00), pulse DONE next cycle, go to IDLE.
- WR_ADDR:
  - AWVALID and WVALID assert together.
  - Each drops independently after its own handshake, tracked by flags `aw_done` and `w_done`.
  - Go to WR_RESP once both handshakes are complete; same-cycle completion of both is allowed.
- WR_RESP: BREADY=1. On BVALID: ERR=(BRESP≠OKAY), pulse DMEM_DONE, go to IDLE.
- Deasserting REQ mid-transaction is ignored; the transaction completes and DONE still pulses.
- Payload inputs are not observed after the grant cycle.
- RDATA outputs hold their last value until the next completion for that requester.

## Timing
- Reset values:
  - All VALID/READY outputs 0; both DONE and ERR 0; RDATA outputs 0.
  - FSM=IDLE; `last_grant`=IMEM, so DMEM wins the first tie.
  - AXI address/data outputs 0.
- Latency:
  - REQ sampled in IDLE at cycle 0 → ARVALID/AWVALID high at cycle 1.
  - AXI response accepted at cycle k → DONE at cycle k+1.
  - Minimum read = 3 cycles REQ→DONE with zero-wait slave.
  - Earliest next grant is the DONE cycle (that requester is masked), so back-to-back alternating requests lose no cycle.
- AXI rules:
  - VALIDs never drop before their handshake.
  - ADDR/DATA/STRB/PROT stay stable while VALID is high.
  - RREADY is high only in RD_DATA; BREADY only in WR_RESP.
- Out-of-phase responses:
  - RVALID outside RD_DATA is not accepted (RREADY=0).
  - BVALID outside WR_RESP is likewise not accepted.
- Reset mid-transaction:
  - All outputs return to reset values immediately.
  - The pending DONE is lost; requesters must reissue.

## Structure
- Add to the shared define header:
  - state encodings (3-bit);
  - AXI_RESP_OKAY=2'b00;
  - AXI_PROT_INSN=3'b100 and AXI_PROT_DATA=3'b000.
- Sub-module `core_arb_rr2`: combinational 2-way round-robin picker (req[1:0], last_grant → grant[1:0]). It is reusable for later DMA/debug ports. FSM, payload registers and AXI drive stay in `core_mem_arbiter`.

## Test plan
- Single IMEM read, ADDR=0x100, zero-wait slave returning 0x00000013 → ARVALID cycle 1 with ARPROT=3'b100, IMEM_DONE cycle 3, IMEM_RDATA=0x00000013, IMEM_ERR=0.
- DMEM store ADDR=0x2000, WDATA=0xDEADBEEF, STRB=4'b0011; AWREADY at cycle 1, WREADY at cycle 3 → AWVALID drops after cycle 1, WVALID held until cycle 3, BREADY from cycle 4, DMEM_DONE the cycle after BVALID.
- IMEM and DMEM both request out of reset with both REQs held → grant order DMEM, IMEM, DMEM, IMEM; no consecutive double grant.
- DMEM load returns RRESP=2'b10 with RDATA=0x12345678 → DMEM_DONE=1, DMEM_ERR=1, DMEM_RDATA=0x12345678; a following IMEM read reports IMEM_ERR=0.
- NRST asserted while in RD_DATA with RVALID pending → ARVALID/RREADY/DONE all 0 immediately, FSM IDLE. After release, a DMEM request is granted first in a tie.
- Slave stalls ARREADY for 5 cycles while the IMEM_ADDR input changes → ARADDR stays at the latched grant address and ARVALID stays high throughout.
